hazard_fwd_ctrl: RTL

- Hazard and forwarding control unit for the 5-stage MIPS pipeline.
- Produces the select codes consumed by the D-, E- and M-stage forwarding muxes, and the D-stage stall.
- Keeps its own shadow pipeline (E, M, W) of register numbers and result-source kinds.
- Tracks a multi-cycle mult/div busy interval.

---
 rtl/hazard_fwd_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: stall and forwarding-select generation for a 5-stage MIPS pipeline.
// Ports: clk, reset (async, active-low); D-stage rs/rt/tuse/a3/src/md_* in; stall, fwd_*, md_busy out.
module hazard_fwd_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] a3_D,
  input  logic [1:0] src_D,
  input  logic [1:0] md_start_D,
  input  logic       md_use_D,
  output logic       stall,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [2:0] fwd_rs_E,
  output logic [2:0] fwd_rt_E,
  output logic [1:0] fwd_rt_M,
  output logic       md_busy
);

  localparam logic [1:0] SRC_ALU  = 2'd0;
  localparam logic [1:0] SRC_MEM  = 2'd1;
  localparam logic [1:0] SRC_PC8  = 2'd2;
  localparam logic [1:0] SRC_NONE = 2'd3;

  localparam logic [1:0] MD_MUL = 2'd1;

  localparam int CMAX =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    logic [1:0] src;
  } e_t;

  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] a3;
    logic [1:0] src;
  } m_t;

  typedef struct packed {
    logic [4:0] a3;
    logic [1:0] src;
  } w_t;

  localparam e_t E_BUB = '{
    rs: 5'd0, rt: 5'd0, a3: 5'd0, src: SRC_NONE
  };
  localparam m_t M_BUB = '{
    rt: 5'd0, a3: 5'd0, src: SRC_NONE
  };
  localparam w_t W_BUB = '{
    a3: 5'd0, src: SRC_NONE
  };

  e_t          e_q;
  m_t          m_q;
  w_t          w_q;
  logic [1:0]  md_e_q;
  logic [CW-1:0] cnt_q;

  logic stall_rs;
  logic stall_rt;
  logic stall_md;

  // A producer only matches when it really writes a nonzero register.
  function automatic logic hit(
    input logic [4:0] a3,
    input logic [1:0] src,
    input logic [4:0] r
  );
    return (r != 5'd0) && (a3 == r) && (src != SRC_NONE);
  endfunction

  function automatic logic [1:0] tnew_e(input logic [1:0] src);
    return (src == SRC_MEM) ? 2'd2 : 2'd1;
  endfunction

  function automatic logic [1:0] tnew_m(input logic [1:0] src);
    return (src == SRC_MEM) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic need_stall(
    input logic [4:0] r,
    input logic [1:0] tuse,
    input e_t         e,
    input m_t         m
  );
    logic ue;
    logic um;
    ue = hit(e.a3, e.src, r) && (tnew_e(e.src) > tuse);
    um = hit(m.a3, m.src, r) && (tnew_m(m.src) > tuse);
    return (tuse != 2'd3) && (ue || um);
  endfunction

  function automatic logic [1:0] sel_d(
    input logic [4:0] r,
    input m_t         m
  );
    logic hm;
    logic [1:0] s;
    hm = hit(m.a3, m.src, r);
    unique case (1'b1)
      hm && (m.src == SRC_ALU): s = 2'd1;
      hm && (m.src == SRC_PC8): s = 2'd2;
      default:                  s = 2'd0;
    endcase
    return s;
  endfunction

  // An M-stage load match blocks the W path; that case is stalled anyway.
  function automatic logic [2:0] sel_e(
    input logic [4:0] r,
    input m_t         m,
    input w_t         w
  );
    logic hm;
    logic hw;
    logic [2:0] s;
    hm = hit(m.a3, m.src, r);
    hw = hit(w.a3, w.src, r);
    unique case (1'b1)
      hm && (m.src == SRC_ALU):         s = 3'd1;
      hm && (m.src == SRC_PC8):         s = 3'd3;
      !hm && hw && (w.src == SRC_PC8):  s = 3'd4;
      !hm && hw && (w.src != SRC_PC8):  s = 3'd2;
      default:                          s = 3'd0;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] sel_m(
    input logic [4:0] r,
    input w_t         w
  );
    logic hw;
    logic [1:0] s;
    hw = hit(w.a3, w.src, r);
    unique case (1'b1)
      hw && (w.src == SRC_PC8): s = 2'd2;
      hw && (w.src != SRC_PC8): s = 2'd1;
      default:                  s = 2'd0;
    endcase
    return s;
  endfunction

  always_comb begin
    stall_rs = need_stall(rs_D, tuse_rs_D, e_q, m_q);
    stall_rt = need_stall(rt_D, tuse_rt_D, e_q, m_q);
    stall_md = md_use_D && ((cnt_q != '0) || (md_e_q != 2'd0));
    stall    = stall_rs || stall_rt || stall_md;
    md_busy  = (cnt_q != '0);
    fwd_rs_D = sel_d(rs_D, m_q);
    fwd_rt_D = sel_d(rt_D, m_q);
    fwd_rs_E = sel_e(e_q.rs, m_q, w_q);
    fwd_rt_E = sel_e(e_q.rt, m_q, w_q);
    fwd_rt_M = sel_m(m_q.rt, w_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q    <= E_BUB;
      m_q    <= M_BUB;
      w_q    <= W_BUB;
      md_e_q <= 2'd0;
      cnt_q  <= '0;
    end else begin
      w_q <= '{a3: m_q.a3, src: m_q.src};
      m_q <= '{rt: e_q.rt, a3: e_q.a3, src: e_q.src};
      if (stall) begin
        e_q    <= E_BUB;
        md_e_q <= 2'd0;
      end else begin
        e_q <= '{
          rs: rs_D, rt: rt_D, a3: a3_D, src: src_D
        };
        md_e_q <= md_start_D;
      end
      if (md_e_q == MD_MUL) begin
        cnt_q <= CW'(MULT_CYCLES);
      end else if (md_e_q != 2'd0) begin
        cnt_q <= CW'(DIV_CYCLES);
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

endmodule
